echo_distance_meter: RTL
========================

Name: echo_distance_meter

Overview:
- Receive side of the ultrasonic ranging interface.
- After the trigger pulse is issued, the block is armed by a start pulse. It then waits for the sensor's echo pulse, measures how long echo stays high in clk cycles, and converts that time to whole centimetres using a prescaler (no divider).
- It reports either a valid distance or a timeout to the Tamagotchi proximity logic.

Parameters:
- CYCLES_PER_CM, 2900, clk cycles per centimetre of distance (58 us at 50 MHz).
- MAX_CM, 400, saturation value for the reported distance.
- TIMEOUT_CYCLES, 1900000, maximum wait for a rising edge, and maximum echo-high duration (38 ms at 50 MHz).
- DIST_W, 9, width of the distance output.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that arms one measurement.
- echo  input  1  raw echo pin from the sensor (asynchronous).
- distance_cm  output  DIST_W  last valid distance in cm; holds its value between measurements.
- valid  output  1  one-cycle pulse when distance_cm has been updated.
- timeout  output  1  one-cycle pulse when a measurement is abandoned.
- busy  output  1  high while in ARMED or MEASURE.

Behaviour:
- Reset (asynchronous, any time):
  - state=IDLE.
  - Synchronizer flops, echo_d, counters, distance_cm, valid, timeout and busy all go to 0.
  - Reset mid-measurement aborts it; no valid or timeout pulse is produced.
- Echo input conditioning:
  - echo passes through a 2-flop synchronizer; echo_s is the second stage.
  - echo_d is echo_s delayed by one cycle.
  - rise = echo_s & ~echo_d; fall = ~echo_s & echo_d.
- Outputs are registered. valid and timeout are high for exactly one cycle and are never high together. busy is 1 exactly when state is ARMED or MEASURE.
- State IDLE:
  - start=1 -> ARMED, wait_cnt=0.
  - The echo input is ignored in this state.
- State ARMED:
  - wait_cnt increments every cycle.
  - rise -> MEASURE, with prescaler=1 (counts the rise cycle), cm_cnt=0, wait_cnt=0.
  - No rise and wait_cnt == TIMEOUT_CYCLES-1 -> IDLE, timeout=1, distance_cm unchanged.
  - If echo is already high at arming, it is ignored until it falls and rises again. A fall in ARMED is ignored.
  - start is ignored.
- State MEASURE, each cycle with echo_s=1:
  - prescaler increments.
  - When prescaler == CYCLES_PER_CM-1, prescaler wraps to 0 and cm_cnt increments, saturating at MAX_CM.
  - wait_cnt increments.
- State MEASURE, on fall:
  - -> IDLE, distance_cm <= cm_cnt, valid=1.
  - There is no prescaler or cm_cnt update on the fall cycle.
  - Result: for N clk cycles of echo_s high, distance_cm = min(floor(N/CYCLES_PER_CM), MAX_CM). The partial centimetre is truncated.
- State MEASURE, long echo:
  - If wait_cnt reaches TIMEOUT_CYCLES-1 with echo still high -> IDLE, timeout=1, distance_cm unchanged.
  - A fall and the timeout condition in the same cycle: fall wins (valid).
- In MEASURE, start is ignored.
- Latency: valid/timeout are asserted after the third rising clk edge at which the echo pin is sampled low. This is 2 cycles of synchronizer plus 1 registered output.
- Widths: prescaler is ceil(log2(CYCLES_PER_CM)) bits. wait_cnt is at least 21 bits for the default TIMEOUT_CYCLES. cm_cnt is DIST_W bits.
- Back-to-back use: start may be asserted on the cycle after valid or timeout and is accepted.

Test Plan:
- Reset during operation: assert rst while in MEASURE with echo high -> busy, valid, timeout and distance_cm are 0 immediately (asynchronously); no pulse follows; a later start is accepted normally.
- Nominal measurement: start, then after 1000 cycles hold echo high for 290000 cycles -> valid once, distance_cm=100, busy=0 afterwards.
- Truncation boundary: echo high for 289999 cycles -> distance_cm=99; for 2900 cycles -> 1; for 2899 cycles -> 0 with valid=1.
- No echo: start with echo held low -> after 1900000 cycles timeout pulses once; distance_cm keeps its previous value (e.g. 100); valid stays 0.
- Saturation and long echo:
  - echo high for 1200000 cycles -> distance_cm=400 (raw 413 saturated).
  - echo high for 2000000 cycles -> timeout at cycle 1900000 of MEASURE; no valid.
- Arming rules:
  - echo already high when start arrives, falls, then rises for 5800 cycles -> distance_cm=2.
  - Second start pulse during MEASURE -> no effect; exactly one valid.
  - Echo pulse while IDLE -> no valid.

Source files
------------

// File: rtl/echo_distance_meter.sv
// -----------------------------------------------------------------------------
// echo_distance_meter
//
// Receive side of an ultrasonic ranging interface. A start pulse arms one
// measurement. The block then waits for a rising edge on the sensor echo pin.
// It counts how many clk cycles the echo stays high and converts that count to
// whole centimetres with a prescaler, so no divider is needed. The result is
// either a valid distance or a timeout.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   start        single-cycle pulse that arms one measurement
//   echo         raw, asynchronous echo pin from the sensor
//   distance_cm  last valid distance in cm; holds between measurements
//   valid        one-cycle pulse when distance_cm has been updated
//   timeout      one-cycle pulse when a measurement is abandoned
//   busy         high while a measurement is armed or in progress
// -----------------------------------------------------------------------------
module echo_distance_meter #(
    parameter int CYCLES_PER_CM  = 2900,
    parameter int MAX_CM         = 400,
    parameter int TIMEOUT_CYCLES = 1900000,
    parameter int DIST_W         = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              echo,
    output logic [DIST_W-1:0] distance_cm,
    output logic              valid,
    output logic              timeout,
    output logic              busy
);

    localparam int PRE_W  = (CYCLES_PER_CM > 1)  ? $clog2(CYCLES_PER_CM)  : 1;
    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CYCLES_PER_CM - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DIST_W-1:0] CM_MAX    = DIST_W'(MAX_CM);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Echo conditioning: two synchronizer stages, then one extra delay stage
    // (echo_dly_q) used only for edge detection.
    logic echo_meta_q, echo_meta_d;
    logic echo_s_q,    echo_s_d;
    logic echo_dly_q,  echo_dly_d;

    logic [WAIT_W-1:0] wait_cnt_q,  wait_cnt_d;
    logic [PRE_W-1:0]  prescaler_q, prescaler_d;
    logic [DIST_W-1:0] cm_cnt_q,    cm_cnt_d;
    logic [DIST_W-1:0] distance_q,  distance_d;
    logic              valid_q,     valid_d;
    logic              timeout_q,   timeout_d;
    logic              busy_q,      busy_d;

    logic rise;
    logic fall;

    assign rise = echo_s_q & ~echo_dly_q;
    assign fall = ~echo_s_q & echo_dly_q;

    always_comb begin
        echo_meta_d = echo;
        echo_s_d    = echo_meta_q;
        echo_dly_d  = echo_s_q;

        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        prescaler_d = prescaler_q;
        cm_cnt_d    = cm_cnt_q;
        distance_d  = distance_q;
        valid_d     = 1'b0;
        timeout_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ARMED;
                    wait_cnt_d = '0;
                end
            end

            ARMED: begin
                // Only a fresh edge starts a measurement. An echo that was
                // already high at arming has to fall and rise again first.
                if (rise) begin
                    state_d     = MEASURE;
                    prescaler_d = PRE_W'(1);  // the rise cycle itself is high
                    cm_cnt_d    = '0;
                    wait_cnt_d  = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            MEASURE: begin
                // A fall takes priority over the timeout check in the same cycle.
                // The fall cycle has echo_s low, so it adds nothing to the count.
                if (fall) begin
                    state_d    = IDLE;
                    distance_d = cm_cnt_q;
                    valid_d    = 1'b1;
                end else if (echo_s_q) begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                        if (prescaler_q == PRE_LAST) begin
                            prescaler_d = '0;
                            if (cm_cnt_q != CM_MAX) begin
                                cm_cnt_d = cm_cnt_q + 1'b1;
                            end
                        end else begin
                            prescaler_d = prescaler_q + 1'b1;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // busy is registered from the next state so that it matches the
        // state register cycle for cycle.
        busy_d = (state_d == ARMED) || (state_d == MEASURE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
            echo_dly_q  <= 1'b0;
            wait_cnt_q  <= '0;
            prescaler_q <= '0;
            cm_cnt_q    <= '0;
            distance_q  <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            echo_meta_q <= echo_meta_d;
            echo_s_q    <= echo_s_d;
            echo_dly_q  <= echo_dly_d;
            wait_cnt_q  <= wait_cnt_d;
            prescaler_q <= prescaler_d;
            cm_cnt_q    <= cm_cnt_d;
            distance_q  <= distance_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    assign distance_cm = distance_q;
    assign valid       = valid_q;
    assign timeout     = timeout_q;
    assign busy        = busy_q;

endmodule
